// File: rtl/otp_keypad_entry_if.sv
`default_nettype none
// ============================================================================
// Module      : otp_keypad_entry_if
// Description : Keypad / OTP-checker signal bundle for otp_keypad_entry.
//               master = keypad side (drives keys), slave = entry controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface otp_keypad_entry_if;
   logic        req_access;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_enter;
   logic        key_clear;
   logic        key_back;
   logic        alarm;
   logic [31:0] user_entered_otp;
   logic        enter_otp;
   logic        entry_active;
   logic [3:0]  digit_count;
   logic        timeout;

   modport master (
      output req_access, key_valid, key_code, key_enter, key_clear, key_back, alarm,
      input  user_entered_otp, enter_otp, entry_active, digit_count, timeout
   );

   modport slave (
      input  req_access, key_valid, key_code, key_enter, key_clear, key_back, alarm,
      output user_entered_otp, enter_otp, entry_active, digit_count, timeout
   );
endinterface
`default_nettype wire

// File: rtl/otp_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module      : otp_keypad_entry
// Description : Collects up to MAX_DIGITS hex nibbles from a keypad into a
//               right-justified 32-bit OTP, supports clear/backspace/enter,
//               aborts idle sessions after TIMEOUT_CYCLES, locks on alarm.
// Revision    : 1.0 - initial release
// ============================================================================
module otp_keypad_entry #(
   parameter int MAX_DIGITS     = 8,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  wire logic          clk,
   input  wire logic          rst,
   otp_keypad_entry_if.slave  bus
);

   localparam int IW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [1:0] c_idle    = 2'd0;
   localparam logic [1:0] c_collect = 2'd1;
   localparam logic [1:0] c_submit  = 2'd2;
   localparam logic [1:0] c_locked  = 2'd3;

   localparam logic [3:0]    c_max_digits = 4'(MAX_DIGITS);
   localparam logic [IW-1:0] c_idle_last  = IW'(TIMEOUT_CYCLES - 1);

   logic [1:0]    state_q, state_d;
   logic [31:0]   acc_q, acc_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [IW-1:0] idle_q, idle_d;
   logic          enter_q, enter_d;
   logic          timeout_q, timeout_d;
   logic          any_strobe;

   // Any keypad strobe, acted on or not, counts as user activity.
   assign any_strobe = bus.key_valid | bus.key_enter | bus.key_clear | bus.key_back;

   // Next-state logic: alarm overrides everything, then per-state key handling
   // with priority clear > back > enter > digit.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      idle_d    = idle_q;
      enter_d   = 1'b0;
      timeout_d = 1'b0;
      if (bus.alarm) begin
         state_d = c_locked;
         acc_d   = '0;
         cnt_d   = '0;
         idle_d  = '0;
      end else begin
         case (state_q)
            c_idle: begin
               if (bus.req_access) begin
                  state_d = c_collect;
                  acc_d   = '0;
                  cnt_d   = '0;
                  idle_d  = '0;
               end
            end
            c_collect: begin
               if (any_strobe) begin
                  idle_d = '0;
                  if (bus.key_clear) begin
                     acc_d = '0;
                     cnt_d = '0;
                  end else if (bus.key_back) begin
                     if (cnt_q != 4'd0) begin
                        acc_d = acc_q >> 4;
                        cnt_d = cnt_q - 4'd1;
                     end
                  end else if (bus.key_enter) begin
                     if (cnt_q != 4'd0) begin
                        state_d = c_submit;
                        enter_d = 1'b1;
                     end
                  end else if (cnt_q < c_max_digits) begin
                     acc_d = {acc_q[27:0], bus.key_code};
                     cnt_d = cnt_q + 4'd1;
                  end
               end else if (idle_q == c_idle_last) begin
                  state_d   = c_idle;
                  acc_d     = '0;
                  cnt_d     = '0;
                  idle_d    = '0;
                  timeout_d = 1'b1;
               end else begin
                  idle_d = idle_q + 1'b1;
               end
            end
            c_submit: state_d = c_idle;
            c_locked: state_d = c_idle;
            default:  state_d = c_idle;
         endcase
      end
   end

   // State registers; reset wins over alarm and keys.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= c_idle;
         acc_q     <= '0;
         cnt_q     <= '0;
         idle_q    <= '0;
         enter_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         idle_q    <= idle_d;
         enter_q   <= enter_d;
         timeout_q <= timeout_d;
      end
   end

   // The accumulator register doubles as the OTP output: it holds the
   // submitted value in IDLE and is cleared when the next session starts.
   assign bus.user_entered_otp = acc_q;
   assign bus.enter_otp        = enter_q;
   assign bus.entry_active     = (state_q == c_collect);
   assign bus.digit_count      = cnt_q;
   assign bus.timeout          = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_otp_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_otp_keypad_entry
// Description : Self-checking bench for otp_keypad_entry (MAX_DIGITS=8,
//               TIMEOUT_CYCLES=10). Vector table plus a timeout sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_otp_keypad_entry;

   typedef struct {
      logic        rst, req, kv;
      logic [3:0]  code;
      logic        ent, clr, bck, alm;
      logic [31:0] otp;
      logic        eo, act;
      logic [3:0]  cnt;
      logic        to;
   } vec_t;

   typedef struct {
      logic [31:0] otp;
      logic        eo, act;
      logic [3:0]  cnt;
      logic        to;
      int          id;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;
   vec_t tbl[$];
   exp_t sb[$];

   otp_keypad_entry_if bus ();

   otp_keypad_entry #(.MAX_DIGITS(8), .TIMEOUT_CYCLES(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, req, kv, input logic [3:0] code,
                               input logic ent, clr, bck, alm,
                               input logic [31:0] otp, input logic eo, act,
                               input logic [3:0] cnt, input logic to);
      vec_t v;
      v.rst = r;   v.req = req; v.kv = kv;   v.code = code;
      v.ent = ent; v.clr = clr; v.bck = bck; v.alm = alm;
      v.otp = otp; v.eo = eo;   v.act = act; v.cnt = cnt; v.to = to;
      return v;
   endfunction

   // Drive one cycle of inputs, queue the expectation, compare after the edge.
   task automatic step(input vec_t v, input int id);
      exp_t e, a;
      @(negedge clk);
      rst            = v.rst;
      bus.req_access = v.req;
      bus.key_valid  = v.kv;
      bus.key_code   = v.code;
      bus.key_enter  = v.ent;
      bus.key_clear  = v.clr;
      bus.key_back   = v.bck;
      bus.alarm      = v.alm;
      e.otp = v.otp; e.eo = v.eo; e.act = v.act; e.cnt = v.cnt; e.to = v.to; e.id = id;
      sb.push_back(e);
      @(posedge clk);
      #1;
      a = sb.pop_front();
      n_checks++;
      if (bus.user_entered_otp === a.otp && bus.enter_otp === a.eo &&
          bus.entry_active === a.act && bus.digit_count === a.cnt && bus.timeout === a.to) begin
         n_pass++;
      end else begin
         $display("FAIL step%0d: got otp=%h eo=%b act=%b cnt=%0d to=%b, expected otp=%h eo=%b act=%b cnt=%0d to=%b",
                  a.id, bus.user_entered_otp, bus.enter_otp, bus.entry_active, bus.digit_count,
                  bus.timeout, a.otp, a.eo, a.act, a.cnt, a.to);
      end
   endtask

   initial begin
      bus.req_access = 1'b0; bus.key_valid = 1'b0; bus.key_code = 4'h0;
      bus.key_enter  = 1'b0; bus.key_clear = 1'b0; bus.key_back = 1'b0;
      bus.alarm      = 1'b0;

      //                rst req kv code  ent clr bck alm   otp           eo act cnt to
      // Reset, then 1,3,5,7,9 + enter
      tbl.push_back(mk(1, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 4'h0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 4'h1, 0, 0, 0, 0, 32'h1,        0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 1, 4'h3, 0, 0, 0, 0, 32'h13,       0, 1, 2, 0));
      tbl.push_back(mk(0, 0, 1, 4'h5, 0, 0, 0, 0, 32'h135,      0, 1, 3, 0));
      tbl.push_back(mk(0, 0, 1, 4'h7, 0, 0, 0, 0, 32'h1357,     0, 1, 4, 0));
      tbl.push_back(mk(0, 0, 1, 4'h9, 0, 0, 0, 0, 32'h13579,    0, 1, 5, 0));
      tbl.push_back(mk(0, 0, 0, 4'h0, 1, 0, 0, 0, 32'h13579,    1, 0, 5, 0));
      tbl.push_back(mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 32'h13579,    0, 0, 5, 0));
      // Keys ignored in IDLE, submitted value held
      tbl.push_back(mk(0, 0, 1, 4'h4, 1, 0, 0, 0, 32'h13579,    0, 0, 5, 0));
      // A..F, back, E, enter
      tbl.push_back(mk(0, 1, 0, 4'h0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 4'hA, 0, 0, 0, 0, 32'hA,        0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 1, 4'hB, 0, 0, 0, 0, 32'hAB,       0, 1, 2, 0));
      tbl.push_back(mk(0, 0, 1, 4'hC, 0, 0, 0, 0, 32'hABC,      0, 1, 3, 0));
      tbl.push_back(mk(0, 0, 1, 4'hD, 0, 0, 0, 0, 32'hABCD,     0, 1, 4, 0));
      tbl.push_back(mk(0, 0, 1, 4'hE, 0, 0, 0, 0, 32'hABCDE,    0, 1, 5, 0));
      tbl.push_back(mk(0, 0, 1, 4'hF, 0, 0, 0, 0, 32'hABCDEF,   0, 1, 6, 0));
      tbl.push_back(mk(0, 0, 0, 4'h0, 0, 0, 1, 0, 32'hABCDE,    0, 1, 5, 0));
      tbl.push_back(mk(0, 0, 1, 4'hE, 0, 0, 0, 0, 32'hABCDEE,   0, 1, 6, 0));
      tbl.push_back(mk(0, 0, 0, 4'h0, 1, 0, 0, 0, 32'hABCDEE,   1, 0, 6, 0));
      tbl.push_back(mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 32'hABCDEE,   0, 0, 6, 0));
      // Nine digits saturate at eight; clear; enter at zero; back at zero
      tbl.push_back(mk(0, 1, 0, 4'h0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 4'h1, 0, 0, 0, 0, 32'h1,        0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 1, 4'h2, 0, 0, 0, 0, 32'h12,       0, 1, 2, 0));
      tbl.push_back(mk(0, 0, 1, 4'h3, 0, 0, 0, 0, 32'h123,      0, 1, 3, 0));
      tbl.push_back(mk(0, 0, 1, 4'h4, 0, 0, 0, 0, 32'h1234,     0, 1, 4, 0));
      tbl.push_back(mk(0, 0, 1, 4'h5, 0, 0, 0, 0, 32'h12345,    0, 1, 5, 0));
      tbl.push_back(mk(0, 0, 1, 4'h6, 0, 0, 0, 0, 32'h123456,   0, 1, 6, 0));
      tbl.push_back(mk(0, 0, 1, 4'h7, 0, 0, 0, 0, 32'h1234567,  0, 1, 7, 0));
      tbl.push_back(mk(0, 0, 1, 4'h8, 0, 0, 0, 0, 32'h12345678, 0, 1, 8, 0));
      tbl.push_back(mk(0, 0, 1, 4'h9, 0, 0, 0, 0, 32'h12345678, 0, 1, 8, 0));
      tbl.push_back(mk(0, 0, 0, 4'h0, 0, 1, 0, 0, 32'h0,        0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 4'h0, 1, 0, 0, 0, 32'h0,        0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 4'h0, 0, 0, 1, 0, 32'h0,        0, 1, 0, 0));
      // req_access inside COLLECT does not restart
      tbl.push_back(mk(0, 0, 1, 4'h1, 0, 0, 0, 0, 32'h1,        0, 1, 1, 0));
      tbl.push_back(mk(0, 1, 0, 4'h0, 0, 0, 0, 0, 32'h1,        0, 1, 1, 0));
      // Strobe priority
      tbl.push_back(mk(0, 0, 1, 4'h4, 0, 0, 0, 0, 32'h14,       0, 1, 2, 0));
      tbl.push_back(mk(0, 0, 1, 4'h7, 0, 0, 1, 0, 32'h1,        0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 1, 4'h7, 1, 1, 1, 0, 32'h0,        0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 4'h9, 1, 0, 1, 0, 32'h0,        0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 4'h6, 0, 0, 0, 0, 32'h6,        0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 4'h0, 1, 0, 1, 0, 32'h0,        0, 1, 0, 0));
      // Digit + enter together at count 2: digit dropped, 0x12 submitted
      tbl.push_back(mk(0, 0, 1, 4'h1, 0, 0, 0, 0, 32'h1,        0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 1, 4'h2, 0, 0, 0, 0, 32'h12,       0, 1, 2, 0));
      tbl.push_back(mk(0, 0, 1, 4'h5, 1, 0, 0, 0, 32'h12,       1, 0, 2, 0));
      tbl.push_back(mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 32'h12,       0, 0, 2, 0));
      // Alarm with enter mid-entry; keys ignored while locked; release
      tbl.push_back(mk(0, 1, 0, 4'h0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 4'h2, 0, 0, 0, 0, 32'h2,        0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 1, 4'h8, 0, 0, 0, 0, 32'h28,       0, 1, 2, 0));
      tbl.push_back(mk(0, 0, 0, 4'h0, 1, 0, 0, 1, 32'h0,        0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 4'h3, 0, 0, 0, 1, 32'h0,        0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 4'h0, 1, 0, 0, 1, 32'h0,        0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 4'h0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 4'h0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 0));
      // Reset mid-session beats alarm and keys
      tbl.push_back(mk(0, 0, 1, 4'h5, 0, 0, 0, 0, 32'h5,        0, 1, 1, 0));
      tbl.push_back(mk(1, 0, 1, 4'h7, 1, 0, 0, 1, 32'h0,        0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0));
      // Alarm in IDLE locks, release returns to IDLE
      tbl.push_back(mk(0, 1, 0, 4'h0, 0, 0, 0, 1, 32'h0,        0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

      // Timeout: two digits, then ten strobe-free cycles abort the session
      step(mk(0, 1, 0, 4'h0, 0, 0, 0, 0, 32'h0,  0, 1, 0, 0), 100);
      step(mk(0, 0, 1, 4'h1, 0, 0, 0, 0, 32'h1,  0, 1, 1, 0), 101);
      step(mk(0, 0, 1, 4'h2, 0, 0, 0, 0, 32'h12, 0, 1, 2, 0), 102);
      for (int k = 1; k <= 9; k++)
         step(mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 32'h12, 0, 1, 2, 0), 102 + k);
      step(mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 1), 112);
      step(mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 0), 113);

      // An ignored strobe (enter at count 0) still restarts the idle count
      step(mk(0, 1, 0, 4'h0, 0, 0, 0, 0, 32'h0,  0, 1, 0, 0), 120);
      for (int k = 1; k <= 8; k++)
         step(mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 0), 120 + k);
      step(mk(0, 0, 0, 4'h0, 1, 0, 0, 0, 32'h0,  0, 1, 0, 0), 129);
      for (int k = 1; k <= 9; k++)
         step(mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 0), 129 + k);
      step(mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 1), 139);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
